// File: rtl/mem_stage.sv
// RV32I memory stage: data-memory req/gnt/rvalid sequencing, LSU lane steering and
// load extension, MEM/WB register. Optional misalignment trap: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              ex_valid,
   input  logic [31:0]       opr_res,
   input  logic [31:0]       rs2_data,
   input  logic [4:0]        rd,
   input  logic              rf_en,
   input  logic [1:0]        wb_sel,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   output logic              mem_stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              misalign_exc,
`endif
   output logic              wb_valid,
   output logic [31:0]       wb_opr_res,
   output logic [31:0]       wb_dmem_rdata,
   output logic [31:0]       wb_lsu_rdata,
   output logic [4:0]        wb_rd,
   output logic              wb_rf_en,
   output logic [1:0]        wb_sel_o
);

   // Handshake: a request transfers on a cycle with dmem_req & dmem_gnt; a load's data
   // is taken on the first dmem_rvalid seen in WAIT_RSP, rvalid elsewhere is dropped.
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2} state_e;

   state_e state_q, state_d;
   logic   mem_op, is_store, is_load, misalign;
   logic   req, stall, complete;
   logic [1:0] size;
   logic [3:0] be_raw;
   logic [7:0] ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   logic        wb_valid_q, wb_rf_en_q, misalign_q;
   logic [31:0] wb_opr_res_q, wb_dmem_rdata_q, wb_lsu_rdata_q;
   logic [4:0]  wb_rd_q;
   logic [1:0]  wb_sel_q;

   assign mem_op   = ex_valid & (mem_read | mem_write);
   assign is_store = mem_write;
   assign is_load  = mem_read & ~mem_write;
   assign size     = funct3[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   // Sizes 10/11 are both word accesses.
   assign misalign = mem_op & (((size == 2'b01) & opr_res[0]) |
                               (size[1] & (opr_res[1:0] != 2'b00)));
   assign misalign_exc = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      req      = 1'b0;
      stall    = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_op & ~misalign) begin
               req = 1'b1;
               if (dmem_gnt) begin
                  if (is_store) complete = 1'b1;
                  else begin
                     state_d = WAIT_RSP;
                     stall   = 1'b1;
                  end
               end else begin
                  state_d = REQ;
                  stall   = 1'b1;
               end
            end else begin
               complete = ex_valid;
            end
         end
         REQ: begin
            req = 1'b1;
            if (dmem_gnt & is_store) begin
               state_d  = IDLE;
               complete = 1'b1;
            end else if (dmem_gnt) begin
               state_d = WAIT_RSP;
               stall   = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         WAIT_RSP: begin
            if (dmem_rvalid) begin
               state_d  = IDLE;
               complete = 1'b1;
            end else begin
               stall = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Upstream inputs may still show a mem op during reset; keep the bus and stall quiet.
   assign dmem_req  = req & arst_n;
   assign mem_stall = stall & arst_n;
   assign dmem_we   = dmem_req & is_store;
   assign dmem_addr = {opr_res[ADDR_W-1:2], 2'b00};

   always_comb begin
      be_raw = 4'b1111;
      case (size)
         2'b00:   be_raw = 4'b0001 << opr_res[1:0];
         2'b01:   be_raw = opr_res[1] ? 4'b1100 : 4'b0011;
         default: be_raw = 4'b1111;
      endcase
   end

   assign dmem_be = dmem_req ? be_raw : 4'b0000;

   always_comb begin
      dmem_wdata = rs2_data;
      case (size)
         2'b00:   dmem_wdata = {4{rs2_data[7:0]}};
         2'b01:   dmem_wdata = {2{rs2_data[15:0]}};
         default: dmem_wdata = rs2_data;
      endcase
   end

   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (opr_res[1:0])
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = opr_res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      ld_ext  = dmem_rdata;
      case (size)
         2'b00:   ld_ext = funct3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = funct3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_ext = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q         <= IDLE;
         wb_valid_q      <= 1'b0;
         wb_rf_en_q      <= 1'b0;
         misalign_q      <= 1'b0;
         wb_opr_res_q    <= 32'd0;
         wb_dmem_rdata_q <= 32'd0;
         wb_lsu_rdata_q  <= 32'd0;
         wb_rd_q         <= 5'd0;
         wb_sel_q        <= 2'd0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= complete;
         misalign_q <= complete & misalign;
         if (complete) begin
            wb_rf_en_q      <= rf_en & ~misalign;
            wb_opr_res_q    <= opr_res;
            wb_dmem_rdata_q <= (is_load & ~misalign) ? dmem_rdata : 32'd0;
            wb_lsu_rdata_q  <= (is_load & ~misalign) ? ld_ext : 32'd0;
            wb_rd_q         <= rd;
            wb_sel_q        <= wb_sel;
         end else begin
            wb_rf_en_q      <= 1'b0;
            wb_opr_res_q    <= 32'd0;
            wb_dmem_rdata_q <= 32'd0;
            wb_lsu_rdata_q  <= 32'd0;
            wb_rd_q         <= 5'd0;
            wb_sel_q        <= 2'd0;
         end
      end
   end

   assign wb_valid      = wb_valid_q;
   assign wb_rf_en      = wb_rf_en_q;
   assign wb_opr_res    = wb_opr_res_q;
   assign wb_dmem_rdata = wb_dmem_rdata_q;
   assign wb_lsu_rdata  = wb_lsu_rdata_q;
   assign wb_rd         = wb_rd_q;
   assign wb_sel_o      = wb_sel_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, store lanes, load extension with
// gnt/rvalid latency, reset mid-transaction and address alignment / trap handling.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        arst_n = 1'b0;
   logic        ex_valid, rf_en, mem_read, mem_write;
   logic [31:0] opr_res, rs2_data, dmem_rdata;
   logic [4:0]  rd;
   logic [1:0]  wb_sel;
   logic [2:0]  funct3;
   logic        dmem_gnt, dmem_rvalid;
   logic        mem_stall, dmem_req, dmem_we, wb_valid, wb_rf_en;
   logic [31:0] dmem_addr, dmem_wdata, wb_opr_res, wb_dmem_rdata, wb_lsu_rdata;
   logic [3:0]  dmem_be;
   logic [4:0]  wb_rd;
   logic [1:0]  wb_sel_o;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign_exc;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage #(.ADDR_W(32)) dut (
      .clk(clk), .arst_n(arst_n), .ex_valid(ex_valid), .opr_res(opr_res),
      .rs2_data(rs2_data), .rd(rd), .rf_en(rf_en), .wb_sel(wb_sel),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign_exc(misalign_exc),
`endif
      .wb_valid(wb_valid), .wb_opr_res(wb_opr_res), .wb_dmem_rdata(wb_dmem_rdata),
      .wb_lsu_rdata(wb_lsu_rdata), .wb_rd(wb_rd), .wb_rf_en(wb_rf_en),
      .wb_sel_o(wb_sel_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      ex_valid    = 1'b0;
      rf_en       = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      opr_res     = 32'd0;
      rs2_data    = 32'd0;
      rd          = 5'd0;
      wb_sel      = 2'd0;
      funct3      = 3'd0;
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      dmem_rdata  = 32'd0;
   endtask

   task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rs2);
      ex_valid  = 1'b1;
      rf_en     = rd_op;
      mem_read  = rd_op;
      mem_write = wr_op;
      funct3    = f3;
      opr_res   = addr;
      rs2_data  = rs2;
      rd        = 5'd7;
      wb_sel    = 2'd1;
   endtask

   task automatic test_reset();
      drive_idle();
      #2;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got %0h want 0", wb_valid); end
      n_checks++; if (wb_rf_en !== 1'b0) begin n_fail++; $display("FAIL rst_wb_rf_en got %0h want 0", wb_rf_en); end
      n_checks++; if (wb_opr_res !== 32'd0) begin n_fail++; $display("FAIL rst_wb_opr_res got %0h want 0", wb_opr_res); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0h want 0", mem_stall); end
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got %0h want 0", dmem_req); end
      #5 arst_n = 1'b1;
   endtask

   task automatic test_alu();
      step();
      drive_idle();
      ex_valid = 1'b1; opr_res = 32'h1234; rd = 5'd5; rf_en = 1'b1; wb_sel = 2'd0;
      #2;
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %0h want 0", mem_stall); end
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req got %0h want 0", dmem_req); end
      step();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid got %0h want 1", wb_valid); end
      n_checks++; if (wb_opr_res !== 32'h1234) begin n_fail++; $display("FAIL alu_wb_opr_res got %0h want 1234", wb_opr_res); end
      n_checks++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_wb_rd got %0d want 5", wb_rd); end
      n_checks++; if (wb_rf_en !== 1'b1) begin n_fail++; $display("FAIL alu_wb_rf_en got %0h want 1", wb_rf_en); end
      n_checks++; if (wb_sel_o !== 2'd0) begin n_fail++; $display("FAIL alu_wb_sel got %0h want 0", wb_sel_o); end
      drive_idle();
      step();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0h want 0", wb_valid); end
   endtask

   task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rs2, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_addr);
      step();
      drive_op(1'b0, 1'b1, f3, addr, rs2);
      dmem_gnt = 1'b1;
      #2;
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL %s_req got %0h want 1", name, dmem_req); end
      n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL %s_we got %0h want 1", name, dmem_we); end
      n_checks++; if (dmem_be !== exp_be) begin n_fail++; $display("FAIL %s_be got %b want %b", name, dmem_be, exp_be); end
      n_checks++; if (dmem_wdata !== exp_wdata) begin n_fail++; $display("FAIL %s_wdata got %h want %h", name, dmem_wdata, exp_wdata); end
      n_checks++; if (dmem_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr got %h want %h", name, dmem_addr, exp_addr); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall got %0h want 0", name, mem_stall); end
      step();
      drive_idle();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL %s_wb_valid got %0h want 1", name, wb_valid); end
      n_checks++; if (wb_dmem_rdata !== 32'd0) begin n_fail++; $display("FAIL %s_wb_rdata got %h want 0", name, wb_dmem_rdata); end
   endtask

   task automatic test_store_delayed();
      step();
      drive_op(1'b0, 1'b1, 3'b010, 32'h0000_1008, 32'h0BAD_F00D);
      #2;
      n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL swd_stall0 got %0h want 1", mem_stall); end
      n_checks++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL swd_req0 got %0h want 1", dmem_req); end
      step();
      dmem_gnt = 1'b1;
      #2;
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL swd_stall1 got %0h want 0", mem_stall); end
      n_checks++; if (dmem_be !== 4'b1111) begin n_fail++; $display("FAIL swd_be got %b want 1111", dmem_be); end
      n_checks++; if (dmem_wdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL swd_wdata got %h want 0badf00d", dmem_wdata); end
      step();
      drive_idle();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL swd_wb_valid got %0h want 1", wb_valid); end
   endtask

   // gnt arrives in cycle 2, rvalid in cycle 5: five stalled cycles.
   task automatic test_load_slow(input string name, input logic [2:0] f3, input logic [31:0] exp);
      int stalls = 0;
      step();
      drive_op(1'b1, 1'b0, f3, 32'h0000_2001, 32'd0);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) step();
         dmem_gnt    = (c == 2);
         dmem_rvalid = (c == 5);
         dmem_rdata  = (c == 5) ? 32'h0000_F000 : 32'hDEAD_BEEF;
         #2;
         if (mem_stall === 1'b1) stalls++;
         n_checks++; if (dmem_req !== (c <= 2)) begin n_fail++; $display("FAIL %s_req_c%0d got %0h want %0h", name, c, dmem_req, (c <= 2)); end
         if (c >= 1) begin
            n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL %s_bubble_c%0d got %0h want 0", name, c, wb_valid); end
         end
      end
      n_checks++; if (stalls != 5) begin n_fail++; $display("FAIL %s_stall_cycles got %0d want 5", name, stalls); end
      step();
      drive_idle();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL %s_wb_valid got %0h want 1", name, wb_valid); end
      n_checks++; if (wb_lsu_rdata !== exp) begin n_fail++; $display("FAIL %s_lsu got %h want %h", name, wb_lsu_rdata, exp); end
      n_checks++; if (wb_dmem_rdata !== 32'h0000_F000) begin n_fail++; $display("FAIL %s_rdata got %h want 0000f000", name, wb_dmem_rdata); end
      n_checks++; if (wb_rf_en !== 1'b1) begin n_fail++; $display("FAIL %s_rf_en got %0h want 1", name, wb_rf_en); end
      n_checks++; if (wb_rd !== 5'd7) begin n_fail++; $display("FAIL %s_rd got %0d want 7", name, wb_rd); end
   endtask

   task automatic test_load_fast(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] rdata, input logic [31:0] exp_addr,
                                 input logic [31:0] exp);
      step();
      drive_op(1'b1, 1'b0, f3, addr, 32'd0);
      dmem_gnt = 1'b1;
      #2;
      n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall0 got %0h want 1", name, mem_stall); end
      n_checks++; if (dmem_addr !== exp_addr) begin n_fail++; $display("FAIL %s_addr got %h want %h", name, dmem_addr, exp_addr); end
      step();
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdata;
      #2;
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall1 got %0h want 0", name, mem_stall); end
      n_checks++; if (dmem_be !== 4'b0000) begin n_fail++; $display("FAIL %s_be_idle got %b want 0000", name, dmem_be); end
      step();
      drive_idle();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL %s_wb_valid got %0h want 1", name, wb_valid); end
      n_checks++; if (wb_lsu_rdata !== exp) begin n_fail++; $display("FAIL %s_lsu got %h want %h", name, wb_lsu_rdata, exp); end
   endtask

   task automatic test_reset_mid();
      step();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_2000, 32'd0);
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      #2;
      n_checks++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rmid_wait_stall got %0h want 1", mem_stall); end
      arst_n = 1'b0;
      #1;
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got %0h want 0", dmem_req); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_stall got %0h want 0", mem_stall); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_wb_valid got %0h want 0", wb_valid); end
      step();
      drive_idle();
      arst_n = 1'b1;
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1111_2222;
      #2;
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rmid_late_stall got %0h want 0", mem_stall); end
      step();
      dmem_rvalid = 1'b0;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_wb0 got %0h want 0", wb_valid); end
      step();
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_late_wb1 got %0h want 0", wb_valid); end
   endtask

`ifdef MEM_MISALIGN_TRAP_EN
   task automatic test_misalign();
      step();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0);
      #2;
      n_checks++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_req got %0h want 0", dmem_req); end
      n_checks++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %0h want 0", mem_stall); end
      n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL mis_exc_pre got %0h want 0", misalign_exc); end
      step();
      drive_idle();
      n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL mis_wb_valid got %0h want 1", wb_valid); end
      n_checks++; if (wb_rf_en !== 1'b0) begin n_fail++; $display("FAIL mis_wb_rf_en got %0h want 0", wb_rf_en); end
      n_checks++; if (misalign_exc !== 1'b1) begin n_fail++; $display("FAIL mis_exc got %0h want 1", misalign_exc); end
      step();
      n_checks++; if (misalign_exc !== 1'b0) begin n_fail++; $display("FAIL mis_exc_post got %0h want 0", misalign_exc); end
   endtask
`else
   task automatic test_misalign();
      test_load_fast("lw_unal", 3'b010, 32'h0000_3002, 32'hCAFE_BABE, 32'h0000_3000, 32'hCAFE_BABE);
      test_load_fast("lh_odd", 3'b001, 32'h0000_2003, 32'h8001_1234, 32'h0000_2000, 32'hFFFF_8001);
   endtask
`endif

   initial begin
      drive_idle();
      test_reset();
      test_alu();
      test_store("sb", 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 4'b1000, 32'hDDDD_DDDD, 32'h0000_1000);
      test_store("sh", 3'b001, 32'h0000_1002, 32'h1122_3344, 4'b1100, 32'h3344_3344, 32'h0000_1000);
      test_store("sw", 3'b010, 32'h0000_1004, 32'h1122_3344, 4'b1111, 32'h1122_3344, 32'h0000_1004);
      test_store_delayed();
      test_load_slow("lb", 3'b000, 32'hFFFF_FFF0);
      test_load_slow("lbu", 3'b100, 32'h0000_00F0);
      test_load_fast("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 32'h0000_2000, 32'h0000_8001);
      test_load_fast("lh", 3'b001, 32'h0000_2002, 32'h8001_1234, 32'h0000_2000, 32'hFFFF_8001);
      test_load_fast("lw", 3'b010, 32'h0000_2000, 32'h8001_1234, 32'h0000_2000, 32'h8001_1234);
      test_misalign();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
